// File: rtl/laser_pkg.sv
// Shared constants, state encoding and accumulator helper for the laser-coverage scan sequencer.
package laser_pkg;
  localparam int GRID_W   = 4;
  localparam int N_IDX    = 20;
  localparam int CNT_W    = 6;
  localparam int R2       = 16;
  localparam int MAX_PASS = 6;
  localparam int IDX_W    = 5;
  localparam int PASS_W   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    PASS_END = 2'd2,
    FIN      = 2'd3
  } state_t;

  // Per-candidate coverage sum; 2*N_IDX fits CNT_W, so no saturation is needed.
  function automatic logic [CNT_W-1:0] add_hits(input logic [CNT_W-1:0] acc,
                                                input logic [1:0]       hit);
    return acc + {{(CNT_W-2){1'b0}}, hit};
  endfunction
endpackage

// File: rtl/laser_grid_counter.sv
// Point-index and row-major candidate counters for the 16x16 exhaustive scan.
module laser_grid_counter
  import laser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [IDX_W-1:0]  scan_idx,
  output logic [GRID_W-1:0] cand_x,
  output logic [GRID_W-1:0] cand_y,
  output logic              last_idx,
  output logic              last_cand
);
  assign last_idx  = (scan_idx == IDX_W'(N_IDX - 1));
  assign last_cand = last_idx && (&cand_x) && (&cand_y);

  // Index runs 0..N_IDX-1 per candidate; X is the inner axis and wraps into Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx <= '0;
      cand_x   <= '0;
      cand_y   <= '0;
    end else if (clear) begin
      scan_idx <= '0;
      cand_x   <= '0;
      cand_y   <= '0;
    end else if (advance) begin
      if (last_idx) begin
        scan_idx <= '0;
        cand_x   <= cand_x + 4'd1;
        if (&cand_x) begin
          cand_y <= cand_y + 4'd1;
        end
      end else begin
        scan_idx <= scan_idx + 5'd1;
      end
    end
  end
endmodule

// File: rtl/laser_scan_sequencer.sv
// Sequences alternating C1/C2 exhaustive candidate passes and tracks the best-coverage centre.
module laser_scan_sequencer
  import laser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        hit_inc,
  output logic [IDX_W-1:0]  scan_idx,
  output logic [GRID_W-1:0] cand_x,
  output logic [GRID_W-1:0] cand_y,
  output logic [GRID_W-1:0] fix_x,
  output logic [GRID_W-1:0] fix_y,
  output logic              fix_en,
  output logic              busy,
  output logic [GRID_W-1:0] c1x,
  output logic [GRID_W-1:0] c1y,
  output logic [GRID_W-1:0] c2x,
  output logic [GRID_W-1:0] c2y,
  output logic              done
);
  state_t            state, state_next;
  logic [CNT_W-1:0]  acc, best, total;
  logic [PASS_W-1:0] pass_cnt;
  logic              improved, last_idx, last_cand;
  logic              start_acc, grid_clear, goto_fin;

  assign start_acc  = (state == IDLE) && start;
  assign grid_clear = start_acc || (state == PASS_END);
  assign total      = add_hits(acc, hit_inc);
  assign goto_fin   = ((pass_cnt + 3'd1) == PASS_W'(MAX_PASS)) ||
                      ((pass_cnt != 3'd0) && !improved);

  laser_grid_counter u_grid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (grid_clear),
    .advance   (state == SCAN),
    .scan_idx  (scan_idx),
    .cand_x    (cand_x),
    .cand_y    (cand_y),
    .last_idx  (last_idx),
    .last_cand (last_cand)
  );

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start)     state_next = SCAN;     else state_next = IDLE;
      SCAN:     if (last_cand) state_next = PASS_END; else state_next = SCAN;
      PASS_END: if (goto_fin)  state_next = FIN;      else state_next = SCAN;
      FIN:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Accumulate, compare and hand the optimised circle over as the fixed circle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      best     <= '0;
      pass_cnt <= '0;
      improved <= 1'b0;
      c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
      fix_x <= '0; fix_y <= '0; fix_en <= 1'b0;
    end else if (start_acc) begin
      acc      <= '0;
      best     <= '0;
      pass_cnt <= '0;
      improved <= 1'b0;
      c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
      fix_x <= '0; fix_y <= '0; fix_en <= 1'b0;
    end else if (state == SCAN) begin
      if (last_idx) begin
        acc <= '0;
        // best carries across passes: re-scanning the fixed position reproduces it.
        if (total >= best) begin
          best <= total;
          if (total > best) improved <= 1'b1;
          if (pass_cnt[0]) begin
            c2x <= cand_x; c2y <= cand_y;
          end else begin
            c1x <= cand_x; c1y <= cand_y;
          end
        end
      end else begin
        acc <= total;
      end
    end else if (state == PASS_END) begin
      fix_x    <= pass_cnt[0] ? c2x : c1x;
      fix_y    <= pass_cnt[0] ? c2y : c1y;
      fix_en   <= 1'b1;
      pass_cnt <= pass_cnt + 3'd1;
      improved <= 1'b0;
    end
  end

  // Status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SCAN) || (state_next == PASS_END);
      done <= (state_next == FIN);
    end
  end
endmodule

// File: tb/tb_laser_scan_sequencer.sv
// Scoreboard bench: runs push expected results; a done-triggered monitor pops and compares.
module tb_laser_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] hit_inc;
  logic [4:0] scan_idx;
  logic [3:0] cand_x, cand_y, fix_x, fix_y, c1x, c1y, c2x, c2y;
  logic       fix_en, busy, done;

  typedef struct {
    logic [3:0] c1x, c1y, c2x, c2y, fx, fy;
    int         lat;
  } exp_t;

  localparam int M_ZERO = 0, M_PEAK = 1, M_GOLD = 2, M_IMPROVE = 3, M_THREE = 4;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   mode = M_ZERO;

  laser_scan_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_inc(hit_inc),
    .scan_idx(scan_idx), .cand_x(cand_x), .cand_y(cand_y),
    .fix_x(fix_x), .fix_y(fix_y), .fix_en(fix_en), .busy(busy),
    .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the distance/hit datapath, driven from the presented candidate.
  function automatic logic [1:0] stub_hit();
    int p;
    logic at39, at122, at57;
    at39  = (cand_x == 4'd3)  && (cand_y == 4'd9);
    at122 = (cand_x == 4'd12) && (cand_y == 4'd2);
    at57  = (cand_x == 4'd5)  && (cand_y == 4'd7);
    p = (cyc - start_cyc) / 5121;
    case (mode)
      M_PEAK:  return at57 ? 2'd2 : 2'd0;
      M_GOLD:  if (!fix_en) return at39 ? 2'd2 : (at122 ? 2'd1 : 2'd0);
               else         return at122 ? 2'd2 : (at39 ? 2'd1 : 2'd0);
      M_IMPROVE: return (int'(cand_x) == p && int'(cand_y) == p &&
                         int'(scan_idx) < 2 * (p + 1)) ? 2'd2 : 2'd0;
      M_THREE: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  initial begin
    hit_inc = 2'd0;
    forever begin
      @(negedge clk);
      hit_inc = stub_hit();
    end
  end

  // Monitor: every DONE pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_done: got done with empty scoreboard, required none");
      end else begin
        exp_t e;
        int lat;
        e = sb.pop_front();
        lat = cyc - start_cyc + 1;
        if ({c1x, c1y, c2x, c2y} !== {e.c1x, e.c1y, e.c2x, e.c2y}) begin
          errors = errors + 1;
          $display("FAIL result: got C1=(%0d,%0d) C2=(%0d,%0d), required C1=(%0d,%0d) C2=(%0d,%0d)",
                   c1x, c1y, c2x, c2y, e.c1x, e.c1y, e.c2x, e.c2y);
        end
        checks = checks + 1;
        if ({fix_en, fix_x, fix_y} !== {1'b1, e.fx, e.fy}) begin
          errors = errors + 1;
          $display("FAIL fixed: got en=%0d (%0d,%0d), required en=1 (%0d,%0d)",
                   fix_en, fix_x, fix_y, e.fx, e.fy);
        end
        checks = checks + 1;
        if (lat != e.lat) begin
          errors = errors + 1;
          $display("FAIL latency: got %0d cycles, required %0d", lat, e.lat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [3:0] a, b, c, d, fx, fy, input int passes);
    exp_t e;
    e.c1x = a; e.c1y = b; e.c2x = c; e.c2y = d; e.fx = fx; e.fy = fy;
    e.lat = passes * 5121 + 1;
    sb.push_back(e);
  endtask

  task automatic issue_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks = checks + 1;
    if (!seen) begin
      errors = errors + 1;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
    end else begin
      @(negedge clk);
      check("done_pulse_width", {done, busy}, 64'd0);
    end
  endtask

  initial begin
    #2;
    check("reset_outputs", {busy, done, fix_en, scan_idx, cand_x, cand_y, fix_x, fix_y,
                            c1x, c1y, c2x, c2y}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // HIT_INC=3 in IDLE must not start anything.
    mode = M_THREE;
    repeat (10) @(negedge clk);
    check("idle_hit3", {busy, done, scan_idx, cand_x, cand_y, c1x, c1y}, 64'd0);

    // Single peak at (5,7); START pulses while BUSY must be ignored.
    mode = M_PEAK;
    push(4'd5, 4'd7, 4'd5, 4'd7, 4'd5, 4'd7, 2);
    issue_start();
    check("busy_after_start", {busy, scan_idx}, {58'd0, 1'b1, 5'd0});
    repeat (100) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (5200) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(12000);
    repeat (20) @(negedge clk);
    check("hold_after_done", {c1x, c1y, c2x, c2y}, {48'd0, 4'd5, 4'd7, 4'd5, 4'd7});

    // Second START after DONE restarts with results cleared.
    push(4'd5, 4'd7, 4'd5, 4'd7, 4'd5, 4'd7, 2);
    issue_start();
    check("clear_on_start", {c1x, c1y, c2x, c2y, fix_en}, 64'd0);
    wait_done(12000);

    // All ties at zero: later candidate wins, two passes.
    mode = M_ZERO;
    push(4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 2);
    issue_start();
    wait_done(12000);

    // Coverage depends on the fixed circle; pass 1 tie picks a different centre.
    mode = M_GOLD;
    push(4'd3, 4'd9, 4'd12, 4'd2, 4'd12, 4'd2, 2);
    issue_start();
    repeat (5200) @(negedge clk);
    check("fix_in_pass1", {fix_en, fix_x, fix_y}, {55'd0, 1'b1, 4'd3, 4'd9});
    wait_done(12000);

    // Strict gain every pass: runs to MAX_PASS.
    mode = M_IMPROVE;
    push(4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 6);
    issue_start();
    wait_done(32000);

    // Asynchronous reset mid-scan aborts to IDLE.
    mode = M_ZERO;
    issue_start();
    repeat (2000) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mid_scan", {busy, done, fix_en, scan_idx, cand_x, cand_y, fix_x, fix_y,
                                   c1x, c1y, c2x, c2y}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {busy, scan_idx, cand_x, cand_y}, 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
